cordic_word_feeder: RTL and testbench

- Client-side companion to the word-serial CORDIC core. Feeds operand triples into the core's din_valid/rfd load port from an upstream valid/ready stream.
- Captures the core's dout_valid results, which cannot be back-pressured, into a small result FIFO and presents them downstream on a valid/ready stream.
- Credit-based issue guarantees a captured result never finds the FIFO full.

---
 rtl/cordic_word_feeder.sv | 110 +++++++++++
 tb/tb_cordic_word_feeder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_word_feeder.sv
// Client-side feeder for the word-serial CORDIC core: credit-gated operand issue
// on the load port, and a result FIFO that absorbs the core's unstallable result strobes.
module cordic_word_feeder #(
  parameter int unsigned IN_BITS    = 16,
  parameter int unsigned OUT_BITS   = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LOG_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  nGrst,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [IN_BITS-1:0]    s_x,
  input  logic [IN_BITS-1:0]    s_y,
  input  logic [IN_BITS-1:0]    s_a,
  output logic                  din_valid,
  output logic [IN_BITS-1:0]    din_x,
  output logic [IN_BITS-1:0]    din_y,
  output logic [IN_BITS-1:0]    din_a,
  input  logic                  rfd,
  input  logic                  dout_valid,
  input  logic [OUT_BITS-1:0]   out_x,
  input  logic [OUT_BITS-1:0]   out_y,
  input  logic [OUT_BITS-1:0]   out_a,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_BITS-1:0]   m_x,
  output logic [OUT_BITS-1:0]   m_y,
  output logic [OUT_BITS-1:0]   m_a,
  output logic [LOG_DEPTH:0]    in_flight,
  output logic [LOG_DEPTH:0]    fifo_count,
  output logic                  err
);

  localparam int unsigned CNT_W = LOG_DEPTH + 1;
  localparam int unsigned SUM_W = LOG_DEPTH + 2;
  localparam int unsigned RES_W = 3 * OUT_BITS;

  logic [LOG_DEPTH-1:0] r_wr_ptr;
  logic [LOG_DEPTH-1:0] r_rd_ptr;
  logic [CNT_W-1:0]     r_in_flight;
  logic [CNT_W-1:0]     r_fifo_count;
  logic                 r_err;
  logic [RES_W-1:0]     r_mem [FIFO_DEPTH];

  logic                 w_credit_ok;
  logic                 w_issue;
  logic                 w_ret_ok;
  logic                 w_full;
  logic                 w_write;
  logic                 w_drop;
  logic                 w_pop;
  logic [RES_W-1:0]     w_rd_data;

  // Every outstanding op owns a FIFO slot, so a returning result always fits
  assign w_credit_ok = (SUM_W'(r_in_flight) + SUM_W'(r_fifo_count)) < SUM_W'(FIFO_DEPTH);

  assign s_ready   = rfd & w_credit_ok;
  assign din_valid = s_valid & s_ready;
  assign din_x     = s_x;
  assign din_y     = s_y;
  assign din_a     = s_a;
  assign w_issue   = din_valid;

  assign w_ret_ok  = dout_valid & (r_in_flight != '0);
  assign w_full    = (r_fifo_count == CNT_W'(FIFO_DEPTH));
  assign w_write   = w_ret_ok & ~w_full;
  assign w_drop    = dout_valid & ((r_in_flight == '0) | w_full);

  assign m_valid   = (r_fifo_count != '0);
  assign w_pop     = m_valid & m_ready;
  assign w_rd_data = r_mem[r_rd_ptr];
  assign m_x       = w_rd_data[RES_W-1 -: OUT_BITS];
  assign m_y       = w_rd_data[2*OUT_BITS-1 -: OUT_BITS];
  assign m_a       = w_rd_data[OUT_BITS-1:0];

  assign in_flight  = r_in_flight;
  assign fifo_count = r_fifo_count;
  assign err        = r_err;

  // Pointers, counters and sticky error; rst is a synchronous alias of nGrst
  always_ff @(posedge clk or negedge nGrst) begin
    if (!nGrst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_flight  <= '0;
      r_fifo_count <= '0;
      r_err        <= 1'b0;
    end else if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_in_flight  <= '0;
      r_fifo_count <= '0;
      r_err        <= 1'b0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + LOG_DEPTH'(1);
      if (w_pop)   r_rd_ptr <= r_rd_ptr + LOG_DEPTH'(1);
      r_in_flight  <= r_in_flight + CNT_W'(w_issue) - CNT_W'(w_ret_ok);
      r_fifo_count <= r_fifo_count + CNT_W'(w_write) - CNT_W'(w_pop);
      if (w_drop) r_err <= 1'b1;
    end
  end

  // Result storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (w_write) r_mem[r_wr_ptr] <= {out_x, out_y, out_a};
  end

endmodule

// File: tb/tb_cordic_word_feeder.sv
// Bench for cordic_word_feeder: a latency-programmable in-order core model and a
// queue-based reference of the credit/FIFO behaviour, driven with random traffic.
module tb_cordic_word_feeder;

  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = 3 * W;

  logic          clk = 1'b0;
  logic          nGrst = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_x = '0, s_y = '0, s_a = '0;
  logic          din_valid;
  logic [W-1:0]  din_x, din_y, din_a;
  logic          rfd = 1'b1;
  logic          dout_valid = 1'b0;
  logic [W-1:0]  out_x = '0, out_y = '0, out_a = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_x, m_y, m_a;
  logic [2:0]    in_flight, fifo_count;
  logic          err;

  always #5 clk = ~clk;

  cordic_word_feeder #(.IN_BITS(W), .OUT_BITS(W), .FIFO_DEPTH(DEPTH), .LOG_DEPTH(2)) dut (
    .clk(clk), .nGrst(nGrst), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_a(s_a),
    .din_valid(din_valid), .din_x(din_x), .din_y(din_y), .din_a(din_a),
    .rfd(rfd), .dout_valid(dout_valid), .out_x(out_x), .out_y(out_y), .out_a(out_a),
    .m_valid(m_valid), .m_ready(m_ready), .m_x(m_x), .m_y(m_y), .m_a(m_a),
    .in_flight(in_flight), .fifo_count(fifo_count), .err(err)
  );

  typedef struct { int due; logic [RW-1:0] res; } pend_t;

  pend_t          pend[$];
  logic [RW-1:0]  mq[$];
  int             m_if = 0;
  logic           m_err = 1'b0;
  int             n_cmp = 0;
  int             n_fail = 0;
  int             cyc = 0;
  int             last_due = 0;
  logic           core_auto = 1'b0;
  int             lat_min = 1, lat_max = 1;
  logic           man_dv = 1'b0;
  logic [RW-1:0]  man_out = '0;
  logic [W-1:0]   nx = '0, ny = '0, na = '0;

  logic           o_sr, o_dv, o_mv, o_err;
  logic [2:0]     o_if, o_fc;
  logic [RW-1:0]  o_m, o_d;
  logic           e_sr, e_dv, e_mv, e_err;
  logic [2:0]     e_if, e_fc;
  logic [RW-1:0]  e_m, e_d;

  // What the core hands back for a given operand triple
  function automatic logic [RW-1:0] core_fn(input logic [W-1:0] x, y, a);
    return {x ^ 16'h5A5A, y + a, a - x};
  endfunction

  task automatic model_clear();
    m_if = 0; m_err = 1'b0; mq.delete(); pend.delete(); last_due = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    nGrst = 1'b0; rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0; dout_valid = 1'b0; man_dv = 1'b0;
    model_clear();
    @(negedge clk);
    nGrst = 1'b1;
  endtask

  // One clock: drive at negedge, sample just after, advance the reference past the edge
  task automatic cycle(input logic sv, input logic rf, input logic mr, input logic rs);
    logic [RW-1:0] res;
    logic          full, cap_ok;
    int            due;
    @(negedge clk);
    s_valid = sv; rfd = rf; m_ready = mr; rst = rs; s_x = nx; s_y = ny; s_a = na;
    if (core_auto) begin
      dout_valid = (pend.size() > 0) && (pend[0].due <= cyc);
      res = dout_valid ? pend[0].res : RW'({$urandom(), $urandom()});
    end else begin
      dout_valid = man_dv;
      res = man_out;
    end
    {out_x, out_y, out_a} = res;
    #1;
    o_sr = s_ready; o_dv = din_valid; o_mv = m_valid; o_err = err;
    o_if = in_flight; o_fc = fifo_count;
    o_m = {m_x, m_y, m_a}; o_d = {din_x, din_y, din_a};
    e_sr  = rf && ((m_if + mq.size()) < DEPTH);
    e_dv  = sv && e_sr;
    e_mv  = (mq.size() != 0);
    e_m   = e_mv ? mq[0] : '0;
    e_d   = {nx, ny, na};
    e_if  = 3'(m_if);
    e_fc  = 3'(mq.size());
    e_err = m_err;
    full   = (mq.size() == DEPTH);
    cap_ok = dout_valid && (m_if > 0);
    if (e_dv) begin
      if (core_auto) begin
        due = cyc + int'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{due, core_fn(nx, ny, na)});
      end
      nx = 16'($urandom); ny = 16'($urandom); na = 16'($urandom);
    end
    if (dout_valid && (m_if == 0 || full)) m_err = 1'b1;
    if (core_auto && dout_valid) void'(pend.pop_front());
    if (e_mv && mr) void'(mq.pop_front());
    if (cap_ok && !full) mq.push_back(res);
    m_if = m_if + int'(e_dv) - int'(cap_ok);
    if (rs) model_clear();
    @(posedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_cmp++; if ({in_flight, fifo_count, err, m_valid, din_valid} !== 9'd0) begin
      n_fail++; $display("FAIL reset_held: got if=%0d fc=%0d err=%b mv=%b dv=%b want all 0",
                         in_flight, fifo_count, err, m_valid, din_valid); end
    n_cmp++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_held_s_ready: got %b want 1", s_ready); end
    @(negedge clk);
    nGrst = 1'b1;
    model_clear();
    core_auto = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_sr !== 1'b1) begin n_fail++; $display("FAIL idle_s_ready: got %b want 1", o_sr); end
    n_cmp++; if (o_dv !== 1'b0) begin n_fail++; $display("FAIL idle_din_valid: got %b want 0", o_dv); end
    n_cmp++; if (o_mv !== 1'b0) begin n_fail++; $display("FAIL idle_m_valid: got %b want 0", o_mv); end
    n_cmp++; if ({o_if, o_fc, o_err} !== 7'd0) begin
      n_fail++; $display("FAIL idle_counters: got if=%0d fc=%0d err=%b want 0/0/0", o_if, o_fc, o_err); end
  endtask

  task automatic test_single();
    reset_dut();
    core_auto = 1'b0;
    nx = 16'h4000; ny = 16'h0000; na = 16'h2000;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_dv !== 1'b1) begin n_fail++; $display("FAIL single_issue: got %b want 1", o_dv); end
    n_cmp++; if (o_d !== {16'h4000, 16'h0000, 16'h2000}) begin
      n_fail++; $display("FAIL single_din: got %h want 400000002000", o_d); end
    for (int i = 1; i < 30; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (o_if !== 3'd1 || o_mv !== 1'b0) begin
        n_fail++; $display("FAIL single_wait[%0d]: got if=%0d mv=%b want 1/0", i, o_if, o_mv); end
    end
    man_dv = 1'b1; man_out = {16'h1234, 16'h0ABC, 16'h0DEF};
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    man_dv = 1'b0;
    n_cmp++; if (o_mv !== 1'b0) begin n_fail++; $display("FAIL single_no_comb_mvalid: got %b want 0", o_mv); end
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (o_mv !== 1'b1 || o_m[RW-1 -: W] !== 16'h1234 || o_if !== 3'd0 || o_fc !== 3'd1) begin
      n_fail++; $display("FAIL single_result: got mv=%b m_x=%h if=%0d fc=%0d want 1/1234/0/1",
                         o_mv, o_m[RW-1 -: W], o_if, o_fc); end
    n_cmp++; if (o_m !== e_m) begin n_fail++; $display("FAIL single_result_all: got %h want %h", o_m, e_m); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_mv !== 1'b0 || o_fc !== 3'd0) begin
      n_fail++; $display("FAIL single_popped: got mv=%b fc=%0d want 0/0", o_mv, o_fc); end
  endtask

  task automatic test_stall();
    int n_iss, n_pop;
    reset_dut();
    core_auto = 1'b1; lat_min = 5; lat_max = 5;
    n_iss = 0;
    repeat (40) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (o_dv === 1'b1) n_iss++;
      n_cmp++; if (o_sr !== e_sr || o_dv !== e_dv) begin
        n_fail++; $display("FAIL stall_issue: got sr=%b dv=%b want %b/%b", o_sr, o_dv, e_sr, e_dv); end
    end
    n_cmp++; if (n_iss !== 4) begin n_fail++; $display("FAIL stall_issue_count: got %0d want 4", n_iss); end
    n_cmp++; if (o_sr !== 1'b0 || o_fc !== 3'd4 || o_if !== 3'd0) begin
      n_fail++; $display("FAIL stall_full: got sr=%b fc=%0d if=%0d want 0/4/0", o_sr, o_fc, o_if); end
    n_pop = 0;
    repeat (6) begin
      cycle(1'b0, 1'b1, 1'b1, 1'b0);
      if (o_mv === 1'b1) begin
        n_pop++;
        n_cmp++; if (o_m !== e_m) begin n_fail++; $display("FAIL stall_drain_order: got %h want %h", o_m, e_m); end
      end
    end
    n_cmp++; if (n_pop !== 4) begin n_fail++; $display("FAIL stall_drain_count: got %0d want 4", n_pop); end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_dv !== 1'b1) begin n_fail++; $display("FAIL stall_resume: got %b want 1", o_dv); end
    repeat (8) cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_rfd_low();
    reset_dut();
    core_auto = 1'b1; lat_min = 10; lat_max = 10;
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (o_sr !== 1'b0 || o_dv !== 1'b0 || o_if !== 3'd1) begin
        n_fail++; $display("FAIL rfd_low: got sr=%b dv=%b if=%0d want 0/0/1", o_sr, o_dv, o_if); end
    end
    repeat (10) cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_concurrent();
    logic [RW-1:0] r1, r2;
    reset_dut();
    core_auto = 1'b0;
    repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    r1 = RW'({$urandom(), $urandom()});
    r2 = RW'({$urandom(), $urandom()});
    man_dv = 1'b1; man_out = r1;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    man_out = r2;
    cycle(1'b1, 1'b1, 1'b1, 1'b0);
    man_dv = 1'b0;
    n_cmp++; if (o_fc !== 3'd1 || o_if !== 3'd2 || o_dv !== 1'b1 || o_mv !== 1'b1 || o_m !== r1) begin
      n_fail++; $display("FAIL conc_before: got fc=%0d if=%0d dv=%b mv=%b m=%h want 1/2/1/1/%h",
                         o_fc, o_if, o_dv, o_mv, o_m, r1); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_fc !== 3'd1 || o_if !== 3'd2 || o_mv !== 1'b1 || o_m !== r2) begin
      n_fail++; $display("FAIL conc_after: got fc=%0d if=%0d mv=%b m=%h want 1/2/1/%h",
                         o_fc, o_if, o_mv, o_m, r2); end
  endtask

  task automatic test_random();
    reset_dut();
    core_auto = 1'b1; lat_min = 1; lat_max = 7;
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(9, 0) < 7), 1'($urandom_range(9, 0) < 8), 1'($urandom_range(9, 0) < 6), 1'b0);
      n_cmp++; if ({o_sr, o_dv, o_mv, o_if, o_fc, o_err} !== {e_sr, e_dv, e_mv, e_if, e_fc, e_err}) begin
        n_fail++; $display("FAIL rand_ctrl[%0d]: got sr=%b dv=%b mv=%b if=%0d fc=%0d err=%b want %b/%b/%b/%0d/%0d/%b",
                           i, o_sr, o_dv, o_mv, o_if, o_fc, o_err, e_sr, e_dv, e_mv, e_if, e_fc, e_err); end
      if (e_mv) begin
        n_cmp++; if (o_m !== e_m) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, o_m, e_m); end
      end
      if (e_dv) begin
        n_cmp++; if (o_d !== e_d) begin n_fail++; $display("FAIL rand_din[%0d]: got %h want %h", i, o_d, e_d); end
      end
    end
    repeat (20) cycle(1'b0, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_spurious();
    reset_dut();
    core_auto = 1'b0;
    man_dv = 1'b1; man_out = RW'({$urandom(), $urandom()});
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    man_dv = 1'b0;
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_err !== 1'b1 || o_fc !== 3'd0 || o_if !== 3'd0 || o_mv !== 1'b0) begin
      n_fail++; $display("FAIL spurious: got err=%b fc=%0d if=%0d mv=%b want 1/0/0/0", o_err, o_fc, o_if, o_mv); end
    core_auto = 1'b1; lat_min = 3; lat_max = 3;
    repeat (6) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (o_err !== 1'b1 || o_if !== e_if || o_fc !== e_fc) begin
      n_fail++; $display("FAIL spurious_sticky: got err=%b if=%0d fc=%0d want 1/%0d/%0d", o_err, o_if, o_fc, e_if, e_fc); end
    @(negedge clk);
    s_valid = 1'b0; m_ready = 1'b0; dout_valid = 1'b0;
    #2 nGrst = 1'b0;
    #1;
    n_cmp++; if ({in_flight, fifo_count, err, m_valid} !== 8'd0) begin
      n_fail++; $display("FAIL async_reset: got if=%0d fc=%0d err=%b mv=%b want 0/0/0/0",
                         in_flight, fifo_count, err, m_valid); end
    model_clear();
    @(negedge clk);
    nGrst = 1'b1;
  endtask

  task automatic test_sync_rst();
    core_auto = 1'b1; lat_min = 2; lat_max = 2;
    repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    n_cmp++; if ({o_if, o_fc, o_err, o_mv} !== 8'd0 || o_sr !== 1'b1) begin
      n_fail++; $display("FAIL sync_rst: got if=%0d fc=%0d err=%b mv=%b sr=%b want 0/0/0/0/1",
                         o_if, o_fc, o_err, o_mv, o_sr); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall();
    test_rfd_low();
    test_concurrent();
    test_random();
    test_spurious();
    test_sync_rst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
